// File: rtl/circuito_exp4.sv
// circuito_exp4 -- memory-sequence matching game.
//
// A round walks a 16x4 ROM. For every address the player's chaves are
// captured (registra), compared against the ROM word (comparacao) and,
// on a match, the address advances (proximo). A mismatch ends the round
// in fim_errou; matching all 16 words ends it in fim_acertou.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   iniciar      start request (honoured in inicial and both end states)
//   chaves[3:0]  player input, one-hot expected
//   pronto       round finished
//   acertou      all 16 entries matched
//   errou        a mismatch occurred
//   db_igual     comparator result (chaves register == ROM word)
//   db_iniciar   copy of iniciar
//   db_contagem, db_memoria, db_chaves, db_estado [6:0]
//                active-low 7-segment codes (bit0=a .. bit6=g)
//
// Configuration macro CIRCUITO_EXP4_DB_DISPLAY_EN: when defined, the four
// 7-segment debug outputs show the counter, ROM word, chaves register and
// state code; when undefined they are blank (7'b1111111).
module circuito_exp4 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] chv_q, chv_d;
    logic [3:0] rom_word;
    logic       fim_c;
    logic       zera, registra, conta;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        rom_word = 4'b0001;
        case (cnt_q)
            4'h0: rom_word = 4'b0001;
            4'h1: rom_word = 4'b0010;
            4'h2: rom_word = 4'b0100;
            4'h3: rom_word = 4'b1000;
            4'h4: rom_word = 4'b0100;
            4'h5: rom_word = 4'b0010;
            4'h6: rom_word = 4'b0001;
            4'h7: rom_word = 4'b0001;
            4'h8: rom_word = 4'b0010;
            4'h9: rom_word = 4'b0010;
            4'hA: rom_word = 4'b0100;
            4'hB: rom_word = 4'b0100;
            4'hC: rom_word = 4'b1000;
            4'hD: rom_word = 4'b1000;
            4'hE: rom_word = 4'b0001;
            4'hF: rom_word = 4'b0100;
            default: rom_word = 4'b0001;
        endcase
    end

    assign fim_c    = (cnt_q == 4'hF);
    assign db_igual = (chv_q == rom_word);

    // Clear has priority over enable/load so preparacao always starts clean.
    always_comb begin
        cnt_d = cnt_q;
        chv_d = chv_q;
        if (zera) begin
            cnt_d = 4'h0;
            chv_d = 4'h0;
        end else begin
            if (conta)    cnt_d = cnt_q + 4'h1;
            if (registra) chv_d = chaves;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INICIAL;
            cnt_q   <= 4'h0;
            chv_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chv_q   <= chv_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM (next state + Moore control outputs)
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        zera     = 1'b0;
        registra = 1'b0;
        conta    = 1'b0;
        pronto   = 1'b0;
        acertou  = 1'b0;
        errou    = 1'b0;
        case (state_q)
            INICIAL:     if (iniciar) state_d = PREPARACAO;
            PREPARACAO: begin
                zera    = 1'b1;
                state_d = REGISTRA;
            end
            REGISTRA: begin
                registra = 1'b1;
                state_d  = COMPARACAO;
            end
            COMPARACAO: begin
                if (!db_igual)  state_d = FIM_ERROU;
                else if (fim_c) state_d = FIM_ACERTOU;
                else            state_d = PROXIMO;
            end
            PROXIMO: begin
                conta   = 1'b1;
                state_d = REGISTRA;
            end
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) state_d = PREPARACAO;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) state_d = PREPARACAO;
            end
            default:     state_d = INICIAL;
        endcase
    end

    assign db_iniciar = iniciar;

    // ------------------------------------------------------------------
    // Debug displays
    // ------------------------------------------------------------------
`ifdef CIRCUITO_EXP4_DB_DISPLAY_EN
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            4'hF: hex7 = 7'b0001110;
            default: hex7 = 7'b1111111;
        endcase
    endfunction

    assign db_contagem = hex7(cnt_q);
    assign db_memoria  = hex7(rom_word);
    assign db_chaves   = hex7(chv_q);
    assign db_estado   = hex7(state_q);
`else
    assign db_contagem = 7'b1111111;
    assign db_memoria  = 7'b1111111;
    assign db_chaves   = 7'b1111111;
    assign db_estado   = 7'b1111111;
`endif

endmodule

// File: tb/tb_circuito_exp4.sv
// Directed bench for circuito_exp4: reset, a full correct round, an early
// mismatch, restart from fim_errou and a mid-round reset abort.
// Display checks expect blank codes unless CIRCUITO_EXP4_DB_DISPLAY_EN is set.
module tb_circuito_exp4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'h0;
    logic       pronto, acertou, errou, db_igual, db_iniciar;
    logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

    int nvec = 0;
    int nerr = 0;

    // Expected ROM, written out by hand from the requirement table.
    logic [3:0] rom_exp [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                                 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                 4'b1000, 4'b1000, 4'b0001, 4'b0100};

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110;

    circuito_exp4 dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .chaves     (chaves),
        .pronto     (pronto),
        .acertou    (acertou),
        .errou      (errou),
        .db_igual   (db_igual),
        .db_iniciar (db_iniciar),
        .db_contagem(db_contagem),
        .db_memoria (db_memoria),
        .db_chaves  (db_chaves),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] disp(input logic [6:0] g);
`ifdef CIRCUITO_EXP4_DB_DISPLAY_EN
        return g;
`else
        return 7'b1111111;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic p, input logic a, input logic e);
        chk({tag, ".pronto"},  pronto,  p);
        chk({tag, ".acertou"}, acertou, a);
        chk({tag, ".errou"},   errou,   e);
    endtask

    // From registra at address 'a', play one correct entry ending in registra a+1.
    task automatic play_ok(input int a);
        chaves = rom_exp[a];
        tick();
        tick();
        tick();
    endtask

    initial begin
        // ---- reset, then idle with iniciar=0 ----
        #2 reset = 1'b1;
        #1;
        chk("rst_async.state", dut.state_q, 4'h0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("idle.state", dut.state_q, 4'h0);
        chk_flags("idle", 1'b0, 1'b0, 1'b0);
        chk("idle.db_estado",   db_estado,   disp(G0));
        chk("idle.db_contagem", db_contagem, disp(G0));
        chk("idle.db_chaves",   db_chaves,   disp(G0));
        chk("idle.db_memoria",  db_memoria,  disp(G1));
        chk("idle.db_iniciar0", db_iniciar,  1'b0);

        // ---- start pulse ----
        iniciar = 1'b1;
        #1 chk("db_iniciar1", db_iniciar, 1'b1);
        tick();
        chk("start.preparacao", dut.state_q, 4'h1);
        iniciar = 1'b0;
        tick();
        chk("start.registra", dut.state_q, 4'h4);
        chk("start.db_contagem", db_contagem, disp(G0));

        // ---- full correct round ----
        for (int a = 0; a < 15; a++) play_ok(a);
        chk("round.addr15", dut.cnt_q, 4'hF);
        chaves = rom_exp[15];
        tick();
        chk("round.cmp15", dut.state_q, 4'h5);
        chk("round.igual15", db_igual, 1'b1);
        tick();
        chk("win.state", dut.state_q, 4'hA);
        chk_flags("win", 1'b1, 1'b1, 1'b0);
        chk("win.db_estado",   db_estado,   disp(GA));
        chk("win.db_contagem", db_contagem, disp(GF));
        tick();
        chk("win.hold", dut.state_q, 4'hA);
        chk("win.cnt_hold", dut.cnt_q, 4'hF);

        // ---- early mismatch at address 1 ----
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        chk("lose.registra", dut.state_q, 4'h4);
        chaves = 4'b0001;
        tick();
        tick();
        tick();
        chk("lose.addr1", dut.cnt_q, 4'h1);
        chaves = 4'b0001;
        tick();
        chk("lose.igual0", db_igual, 1'b0);
        tick();
        chk("lose.state", dut.state_q, 4'hE);
        chk_flags("lose", 1'b1, 1'b0, 1'b1);
        chk("lose.igual_hold", db_igual, 1'b0);
        chk("lose.db_contagem", db_contagem, disp(G1));
        chk("lose.db_estado",   db_estado,   disp(GE));

        // ---- restart from fim_errou ----
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("restart.state", dut.state_q, 4'h1);
        chk_flags("restart", 1'b0, 1'b0, 1'b0);
        tick();
        chk("restart.cnt", dut.cnt_q, 4'h0);
        chk("restart.chv", dut.chv_q, 4'h0);

        // ---- iniciar ignored mid-round ----
        iniciar = 1'b1;
        chaves = rom_exp[0];
        tick();
        chk("ign.cmp", dut.state_q, 4'h5);
        tick();
        chk("ign.prox", dut.state_q, 4'h6);
        iniciar = 1'b0;
        tick();
        for (int a = 1; a < 5; a++) play_ok(a);
        chaves = rom_exp[5];
        tick();
        chk("abort.cmp5", dut.state_q, 4'h5);
        chk("abort.addr5", dut.cnt_q, 4'h5);

        // ---- asynchronous reset mid-round ----
        #2 reset = 1'b1;
        #1;
        chk("abort.state", dut.state_q, 4'h0);
        chk("abort.cnt",   dut.cnt_q,   4'h0);
        chk("abort.chv",   dut.chv_q,   4'h0);
        chk_flags("abort", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("abort.wait", dut.state_q, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/circuito_exp4.md
CIRCUITO_EXP4 -- requirements
Module: circuito_exp4

Interface
REQ-001 clock  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  reset, asynchronous, active-high.
REQ-003 iniciar  input  1  start request; level sampled on the rising edge.
REQ-004 chaves  input  4  player input, one-hot expected.
REQ-005 pronto  output  1  round finished (either end state).
REQ-006 acertou  output  1  all 16 entries matched.
REQ-007 errou  output  1  a mismatch occurred.
REQ-008 db_igual  output  1  comparator result: registered chaves == ROM word.
REQ-009 db_iniciar  output  1  direct copy of iniciar.
REQ-010 db_contagem, db_memoria, db_chaves, db_estado  output  7 each  active-low 7-segment codes (bit0=a ... bit6=g) of the address counter, the ROM word, the chaves register and the state code.

Function
REQ-011 Datapath SHALL contain:
- 4-bit address counter with clear, enable and terminal flag fimC (address==15);
- 16x4 asynchronous-read ROM;
- 4-bit chaves register with clear and load;
- equality comparator.
REQ-012 ROM contents, address 0..15: 0001,0010,0100,1000,0100,0010,0001,0001,0010,0010,0100,0100,1000,1000,0001,0100.
REQ-013 FSM states and codes: inicial=0, preparacao=1, registra=4, comparacao=5, proximo=6, fim_acertou=A, fim_errou=E.
REQ-014 inicial: iniciar=1 -> preparacao; otherwise stay.
REQ-015 preparacao: clear counter and register -> registra (unconditional).
REQ-016 registra: load chaves into register on the exiting edge -> comparacao.
REQ-017 comparacao, evaluated in priority order:
- mismatch -> fim_errou;
- match and fimC=1 -> fim_acertou;
- match and fimC=0 -> proximo.
REQ-018 proximo: increment counter on the exiting edge -> registra.
REQ-019 Each ROM entry therefore takes 3 cycles: registra, comparacao, proximo.
REQ-020 fim_acertou / fim_errou:
- pronto=1 and acertou=1 or errou=1 respectively;
- counter and register hold their values;
- iniciar=1 -> preparacao (new round); otherwise stay.
REQ-021 Outputs pronto, acertou and errou SHALL be Moore outputs decoded from the state. acertou and errou SHALL never both be 1.
REQ-022 Counter SHALL NOT wrap in normal operation: fimC ends the round before address 15 increments.
REQ-023 iniciar SHALL be ignored in every state except inicial, fim_acertou and fim_errou.
REQ-024 Hex decoder: standard 0-F glyphs, active-low.

Reset
REQ-025 reset=1 SHALL asynchronously force:
- state=inicial, counter=0, register=0000;
- pronto=0, acertou=0, errou=0.
REQ-026 reset asserted mid-round SHALL abort the round immediately. After release, the block waits for iniciar.
REQ-027 Displays after reset: db_estado=7'b1000000 ("0"), db_contagem="0", db_chaves="0", db_memoria="1".

Configuration
REQ-028 Macro CIRCUITO_EXP4_DB_DISPLAY_EN:
- defined: db_contagem, db_memoria, db_chaves and db_estado are driven by the hex decoders;
- undefined: all four are constant 7'b1111111 (blank) and the decoders are omitted.
- Independent of the macro: db_igual and db_iniciar are always driven, and the functional outputs are identical.

Verification
REQ-029 Reset pulse, iniciar=0 for 5 cycles -> state inicial, pronto=acertou=errou=0, db_estado="0".
REQ-030 iniciar pulse 1 cycle -> next states preparacao then registra; db_contagem="0"; db_iniciar tracks iniciar.
REQ-031 Apply the ROM sequence, each value held 3 cycles aligned to registra -> after address 15: fim_acertou, pronto=1, acertou=1, db_estado="A", db_contagem="F".
REQ-032 iniciar, chaves=0001 for address 0 then 0001 for address 1 (expected 0010) -> fim_errou, pronto=1, errou=1, db_igual=0, db_contagem="1", db_estado="E".
REQ-033 In fim_errou, pulse iniciar -> preparacao; counter=0, errou=0, pronto=0.
REQ-034 Assert reset during comparacao at address 5 -> immediately inicial, counter=0, all flags 0.
